detection_box_filter: RTL and testbench

Post-processing stage directly downstream of the detection layer. Captures one frame of B decoded bounding boxes and objectness scores, and discards boxes whose score is below a programmable threshold. Streams the surviving boxes out one per cycle over a valid/ready handshake, and publishes the highest-scoring survivor per frame for the box-selection logic that follows.

---
 rtl/detection_box_filter.sv | 161 ++++++++++++++++
 tb/tb_detection_box_filter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/detection_box_filter.sv
// rtl/detection_box_filter.sv - per-frame score threshold filter with survivor stream and best-box tracking
module detection_box_filter #(
    parameter int B     = 4,
    parameter int W     = 16,
    parameter int IDX_W = (B > 1) ? $clog2(B) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [B*4*W-1:0]     in_boxes,
    input  logic [B*W-1:0]       in_scores,
    input  logic [W-1:0]         threshold,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*W-1:0]       out_box,
    output logic [W-1:0]         out_score,
    output logic [IDX_W-1:0]     out_index,
    output logic                 out_last,
    output logic [IDX_W:0]       kept_count,
    output logic                 best_valid,
    output logic [4*W-1:0]       best_box,
    output logic [W-1:0]         best_score,
    output logic [IDX_W-1:0]     best_index
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state, state_next;
    logic [4*W-1:0]     box_q   [B];
    logic [W-1:0]       score_q [B];
    logic [B-1:0]       pass_mask;
    logic [B-1:0]       pass_in;
    logic [B-1:0]       rest;
    logic [IDX_W-1:0]   cur;
    logic               accept;
    logic               scan_fire;

    logic [W-1:0]       max_score;
    logic [4*W-1:0]     max_box;
    logic [IDX_W-1:0]   max_idx;
    logic [IDX_W:0]     run_count;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == SCAN);
    assign scan_fire = out_valid && out_ready;

    always_comb begin
        pass_in = '0;
        for (int i = 0; i < B; i++) begin
            pass_in[i] = (in_scores[i*W +: W] >= threshold);
        end
    end

    // Lowest surviving index is presented first; rest tells whether anything follows it.
    always_comb begin
        cur = '0;
        for (int i = B - 1; i >= 0; i--) begin
            if (pass_mask[i]) begin
                cur = IDX_W'(i);
            end
        end
        rest = pass_mask & ~(B'(1) << cur);
    end

    always_comb begin
        out_box   = '0;
        out_score = '0;
        out_index = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            out_box   = box_q[cur];
            out_score = score_q[cur];
            out_index = cur;
            out_last  = (rest == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (pass_in != '0) ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (scan_fire && out_last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < B; i++) begin
                box_q[i]   <= '0;
                score_q[i] <= '0;
            end
            pass_mask  <= '0;
            max_score  <= '0;
            max_box    <= '0;
            max_idx    <= '0;
            run_count  <= '0;
            kept_count <= '0;
            best_valid <= 1'b0;
            best_box   <= '0;
            best_score <= '0;
            best_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < B; i++) begin
                            box_q[i]   <= in_boxes[i*4*W +: 4*W];
                            score_q[i] <= in_scores[i*W +: W];
                        end
                        pass_mask <= pass_in;
                        max_score <= '0;
                        max_box   <= '0;
                        max_idx   <= '0;
                        run_count <= '0;
                    end
                end
                SCAN: begin
                    if (scan_fire) begin
                        pass_mask[cur] <= 1'b0;
                        run_count      <= run_count + (IDX_W+1)'(1);
                        // First survivor always loads; later ones only on strictly greater, so ties keep the lower index.
                        if (run_count == '0 || score_q[cur] > max_score) begin
                            max_score <= score_q[cur];
                            max_box   <= box_q[cur];
                            max_idx   <= cur;
                        end
                    end
                end
                DONE: begin
                    kept_count <= run_count;
                    best_valid <= (run_count != '0);
                    best_box   <= (run_count != '0) ? max_box   : '0;
                    best_score <= (run_count != '0) ? max_score : '0;
                    best_index <= (run_count != '0) ? max_idx   : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_detection_box_filter.sv
// tb/tb_detection_box_filter.sv - scoreboard bench for detection_box_filter
module tb_detection_box_filter;

    localparam int B     = 4;
    localparam int W     = 16;
    localparam int IDX_W = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [B*4*W-1:0]   in_boxes = '0;
    logic [B*W-1:0]     in_scores = '0;
    logic [W-1:0]       threshold = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [4*W-1:0]     out_box;
    logic [W-1:0]       out_score;
    logic [IDX_W-1:0]   out_index;
    logic               out_last;
    logic [IDX_W:0]     kept_count;
    logic               best_valid;
    logic [4*W-1:0]     best_box;
    logic [W-1:0]       best_score;
    logic [IDX_W-1:0]   best_index;

    detection_box_filter #(.B(B), .W(W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_boxes   (in_boxes),
        .in_scores  (in_scores),
        .threshold  (threshold),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_box    (out_box),
        .out_score  (out_score),
        .out_index  (out_index),
        .out_last   (out_last),
        .kept_count (kept_count),
        .best_valid (best_valid),
        .best_box   (best_box),
        .best_score (best_score),
        .best_index (best_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] box;
        logic [15:0] score;
        logic [1:0]  idx;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_box(input int i);
        mk_box = {16'h4000 + 16'(i), 16'h3000 + 16'(i), 16'h2000 + 16'(i), 16'h1000 + 16'(i)};
    endfunction

    task automatic push_exp(input int idx, input logic [15:0] score, input logic last);
        exp_t e;
        e.box = mk_box(idx);
        e.score = score;
        e.idx = 2'(idx);
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented box must be expected; every handshake pops and compares.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else if (out_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_index", 64'(out_index), 64'(e.idx));
                check("out_score", 64'(out_score), 64'(e.score));
                check("out_box",   out_box,        e.box);
                check("out_last",  64'(out_last),  64'(e.last));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic accept(input logic [63:0] scores, input logic [15:0] thr);
        for (int i = 0; i < B; i++) in_boxes[i*64 +: 64] = mk_box(i);
        in_scores = scores;
        threshold = thr;
        in_valid  = 1'b1;
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 1;
    endtask

    task automatic finish_frame(input string name, input int exp_cycle, input int kept,
                                input logic bvalid, input int bidx, input logic [15:0] bscore);
        while (!in_ready && cyc < 60) step();
        check({name, "_in_ready_cycle"}, 64'(cyc), 64'(exp_cycle));
        check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_kept_count"}, 64'(kept_count), 64'(kept));
        check({name, "_best_valid"}, 64'(best_valid), 64'(bvalid));
        check({name, "_best_index"}, 64'(best_index), 64'(bidx));
        check({name, "_best_score"}, 64'(best_score), 64'(bscore));
        check({name, "_best_box"}, best_box, bvalid ? mk_box(bidx) : 64'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_in_ready"},   64'(in_ready),   64'd1);
        check({name, "_out_valid"},  64'(out_valid),  64'd0);
        check({name, "_out_last"},   64'(out_last),   64'd0);
        check({name, "_out_index"},  64'(out_index),  64'd0);
        check({name, "_out_box"},    out_box,         64'd0);
        check({name, "_out_score"},  64'(out_score),  64'd0);
        check({name, "_kept_count"}, 64'(kept_count), 64'd0);
        check({name, "_best_valid"}, 64'(best_valid), 64'd0);
        check({name, "_best_box"},   best_box,        64'd0);
        check({name, "_best_score"}, 64'(best_score), 64'd0);
        check({name, "_best_index"}, 64'(best_index), 64'd0);
    endtask

    localparam logic [63:0] S1 = {16'h00FF, 16'h0100, 16'h0200, 16'h0050};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_values("reset");

        // Basic frame: indices 1 then 2 survive.
        push_exp(1, 16'h0200, 1'b0);
        push_exp(2, 16'h0100, 1'b1);
        accept(S1, 16'h0100);
        finish_frame("basic", 4, 2, 1'b1, 1, 16'h0200);

        // No survivors.
        accept({16'h0040, 16'h0030, 16'h0020, 16'h0010}, 16'h0100);
        finish_frame("none", 2, 0, 1'b0, 0, 16'h0000);

        // Tied maximum keeps the lower index.
        push_exp(0, 16'h0300, 1'b0);
        push_exp(1, 16'h0300, 1'b0);
        push_exp(3, 16'h0300, 1'b1);
        accept({16'h0300, 16'h0010, 16'h0300, 16'h0300}, 16'h0200);
        finish_frame("tie", 5, 3, 1'b1, 0, 16'h0300);

        // Stall on index 1 for three cycles; in_valid held during SCAN must be ignored.
        push_exp(1, 16'h0200, 1'b0);
        push_exp(2, 16'h0100, 1'b1);
        out_ready = 1'b0;
        accept(S1, 16'h0100);
        in_scores = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        threshold = 16'h0000;
        in_valid  = 1'b1;
        for (int s = 0; s < 3; s++) begin
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_out_index", 64'(out_index), 64'd1);
            check("stall_out_score", 64'(out_score), 64'h0200);
            check("stall_out_last",  64'(out_last),  64'd0);
            check("stall_out_box",   out_box,        mk_box(1));
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        finish_frame("stall", 7, 2, 1'b1, 1, 16'h0200);

        // Threshold changes after acceptance have no effect on the frame.
        push_exp(1, 16'h0200, 1'b0);
        push_exp(2, 16'h0100, 1'b1);
        accept(S1, 16'h0100);
        threshold = 16'hFFFF;
        finish_frame("thr_change", 4, 2, 1'b1, 1, 16'h0200);

        // Max threshold passes only all-ones scores.
        push_exp(0, 16'hFFFF, 1'b0);
        push_exp(3, 16'hFFFF, 1'b1);
        accept({16'hFFFF, 16'h0000, 16'hFFFE, 16'hFFFF}, 16'hFFFF);
        finish_frame("thr_max", 4, 2, 1'b1, 0, 16'hFFFF);

        // Reset in SCAN after one handshake.
        push_exp(0, 16'h0300, 1'b0);
        push_exp(1, 16'h0300, 1'b0);
        push_exp(3, 16'h0300, 1'b1);
        accept({16'h0300, 16'h0010, 16'h0300, 16'h0300}, 16'h0200);
        step();
        check("pre_reset_queue", 64'(exp_q.size()), 64'd2);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check_reset_values("midreset");
        step();
        rst = 1'b0;
        #1;
        check_reset_values("post_reset");

        // Threshold zero passes every box.
        for (int i = 0; i < B; i++) push_exp(i, 16'hFFFF, i == B - 1);
        accept({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 16'h0000);
        finish_frame("after_reset", 6, 4, 1'b1, 0, 16'hFFFF);

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
